// File: rtl/afe_ro_cfg_arb_if.sv
// Bus bundle for afe_ro_cfg_arb: requester-side request/grant/response lanes plus the
// shared slave-side config port. slave = arbiter view, master = requester/slave-model view.
interface afe_ro_cfg_arb_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req_valid_i;
  logic [N_REQ*11-1:0] req_addr_i;
  logic [N_REQ*32-1:0] req_data_i;
  logic [N_REQ-1:0]    req_rwn_i;
  logic [N_REQ-1:0]    req_gnt_o;
  logic [N_REQ-1:0]    rsp_valid_o;
  logic [31:0]         rsp_data_o;
  logic                rsp_err_o;
  logic [10:0]         cfg_addr_o;
  logic [31:0]         cfg_data_o;
  logic                cfg_rwn_o;
  logic                cfg_valid_o;
  logic [31:0]         cfg_data_i;
  logic                cfg_ready_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_rwn_i, cfg_data_i, cfg_ready_i,
    output req_gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           cfg_addr_o, cfg_data_o, cfg_rwn_o, cfg_valid_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_rwn_i, cfg_data_i, cfg_ready_i,
    input  req_gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           cfg_addr_o, cfg_data_o, cfg_rwn_o, cfg_valid_o
  );
endinterface

// File: rtl/afe_ro_cfg_arb.sv
// Round-robin arbiter funnelling N_REQ config requesters onto one slave port (IDLE/ACCESS/RESP).
// Define AFE_RO_CFG_ARB_TIMEOUT_EN to abort stalled slave accesses after TIMEOUT_CYC cycles.
module afe_ro_cfg_arb #(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input logic             clk_i,
  input logic             rstn_i,
  afe_ro_cfg_arb_if.slave bus
);
  localparam int PW = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic [PW-1:0] idx_reg, idx_next;
  logic [10:0]   addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic          rwn_reg, rwn_next;
  logic [31:0]   rdata_reg, rdata_next;
`ifdef AFE_RO_CFG_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC <= 256) ? 8 : 16;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;
`endif

  logic          any_req;
  logic [PW-1:0] win_idx;
  logic          gnt_en;
  logic          rsp_en;

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return sum[PW-1:0];
  endfunction

  // Walk from the farthest slot back to the pointer so the closest requester wins last.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid_i[rr_index(ptr_reg, i)]) begin
        any_req = 1'b1;
        win_idx = rr_index(ptr_reg, i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rwn_next   = rwn_reg;
    rdata_next = rdata_reg;
    gnt_en     = 1'b0;
    rsp_en     = 1'b0;
`ifdef AFE_RO_CFG_ARB_TIMEOUT_EN
    cnt_next   = cnt_reg;
    err_next   = err_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (any_req && rstn_i) begin
          gnt_en     = 1'b1;
          idx_next   = win_idx;
          addr_next  = bus.req_addr_i[int'(win_idx)*11 +: 11];
          wdata_next = bus.req_data_i[int'(win_idx)*32 +: 32];
          rwn_next   = bus.req_rwn_i[win_idx];
          state_next = ACCESS;
`ifdef AFE_RO_CFG_ARB_TIMEOUT_EN
          cnt_next   = '0;
          err_next   = 1'b0;
`endif
        end
      end
      ACCESS: begin
        // Ready wins over a coinciding timeout, so that case completes normally.
        if (bus.cfg_ready_i) begin
          rdata_next = rwn_reg ? bus.cfg_data_i : 32'h0;
          state_next = RESP;
`ifdef AFE_RO_CFG_ARB_TIMEOUT_EN
          err_next   = 1'b0;
`endif
        end
`ifdef AFE_RO_CFG_ARB_TIMEOUT_EN
        else if (cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
          rdata_next = 32'h0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      RESP: begin
        rsp_en     = 1'b1;
        ptr_next   = rr_index(idx_reg, 1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_reg   <= '0;
      idx_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rwn_reg   <= 1'b0;
      rdata_reg <= '0;
`ifdef AFE_RO_CFG_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rwn_reg   <= rwn_next;
      rdata_reg <= rdata_next;
`ifdef AFE_RO_CFG_ARB_TIMEOUT_EN
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
`endif
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign bus.req_gnt_o[gi]   = gnt_en && (win_idx == PW'(gi));
    assign bus.rsp_valid_o[gi] = rsp_en && (idx_reg == PW'(gi));
  end

  assign bus.rsp_data_o  = rsp_en ? rdata_reg : 32'h0;
`ifdef AFE_RO_CFG_ARB_TIMEOUT_EN
  assign bus.rsp_err_o   = rsp_en && err_reg;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif
  // Slave-side fields only change on a grant, so they hold outside ACCESS for free.
  assign bus.cfg_valid_o = (state_reg == ACCESS);
  assign bus.cfg_addr_o  = addr_reg;
  assign bus.cfg_data_o  = wdata_reg;
  assign bus.cfg_rwn_o   = rwn_reg;

endmodule

// File: doc/afe_ro_cfg_arb.md
AFE_RO_CFG_ARB -- requirements
Module: afe_ro_cfg_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of config requesters (legal 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, max cycles to wait for slave ready (used only with REQ-030).
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  N_REQ  per-requester access request.
REQ-006 req_addr_i  input  N_REQ*11  per-requester address, requester k at bits [11k+10:11k].
REQ-007 req_data_i  input  N_REQ*32  per-requester write data, requester k at bits [32k+31:32k].
REQ-008 req_rwn_i  input  N_REQ  per-requester direction, 1=read, 0=write.
REQ-009 req_gnt_o  output  N_REQ  one-hot grant; request captured in that cycle.
REQ-010 rsp_valid_o  output  N_REQ  one-hot, one-cycle completion pulse.
REQ-011 rsp_data_o  output  32  read data for the completing requester, shared by all requesters.
REQ-012 rsp_err_o  output  1  completion ended by timeout; qualified by rsp_valid_o.
REQ-013 cfg_addr_o, cfg_data_o, cfg_rwn_o  output  11/32/1  slave-side address, write data and direction.
REQ-014 cfg_valid_o  output  1  slave access strobe.
REQ-015 cfg_data_i  input  32  slave read data, valid while cfg_valid_o=1 and cfg_rwn_o=1.
REQ-016 cfg_ready_i  input  1  slave completion, sampled only while cfg_valid_o=1.

Function
REQ-017 SHALL implement FSM with states IDLE, ACCESS, RESP.
REQ-018 IDLE: if any req_valid_i is set, SHALL assert req_gnt_o for exactly one winner combinationally in the same cycle, capture winner addr/data/rwn/index, and go to ACCESS; otherwise stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer p and wraps from N_REQ-1 to 0; after each completion p SHALL become (winner index + 1) mod N_REQ.
REQ-020 req_gnt_o SHALL be 0 in ACCESS and RESP; requests arriving then SHALL wait without loss.
REQ-021 ACCESS: cfg_valid_o SHALL be 1, with cfg_addr_o, cfg_data_o and cfg_rwn_o driven from the captured registers and stable until exit.
REQ-022 ACCESS with cfg_ready_i=1: SHALL capture cfg_data_i if read, else 0, and go to RESP.
REQ-023 RESP: SHALL assert rsp_valid_o[winner] for one cycle, drive rsp_data_o from the captured value, update p, and go to IDLE.
REQ-024 Latency SHALL be: grant in cycle 0, cfg_valid_o in cycles 1..n (n ≥ 1), rsp_valid_o in cycle n+1; peak rate is one access every 3 cycles.
REQ-025 Outside RESP, rsp_data_o SHALL be 0 and rsp_err_o SHALL be 0; outside ACCESS, cfg_valid_o SHALL be 0 and the cfg_* outputs SHALL hold their last values.
REQ-026 A requester holding req_valid_i after its rsp_valid_o SHALL be treated as a new request, subject to round-robin (no back-to-back wins while others wait).
REQ-027 Deasserting req_valid_i after grant SHALL NOT abort the captured access.

Reset
REQ-028 On rstn_i low: state=IDLE, p=0, captured registers=0, all outputs 0, effective immediately (asynchronous).
REQ-029 Reset during ACCESS SHALL drop cfg_valid_o at once; no rsp_valid_o SHALL be issued for the aborted access.

Configuration
REQ-030 Macro AFE_RO_CFG_ARB_TIMEOUT_EN defined: an 8..16-bit counter SHALL clear on ACCESS entry and count ACCESS cycles; if cfg_ready_i stays 0 for TIMEOUT_CYC cycles, SHALL go to RESP with rsp_err_o=1 and rsp_data_o=0.
REQ-031 Macro AFE_RO_CFG_ARB_TIMEOUT_EN undefined: no counter; ACCESS SHALL wait indefinitely; rsp_err_o SHALL be tied 0.
REQ-032 Ready and timeout in the same cycle SHALL count as a normal completion (rsp_err_o=0).

Verification
REQ-033 Single write: req0 write addr 0x000 data 0x1, cfg_ready_i=1 -> gnt0 in cycle 0, cfg_valid_o cycle 1 with addr 0x000/data 0x1/rwn 0, rsp_valid_o[0] cycle 2 with rsp_data_o=0.
REQ-034 Read with wait: req1 read addr 0x000, ready delayed 3 cycles, cfg_data_i=0x1 -> cfg_valid_o held 4 cycles with stable outputs, rsp_valid_o[1] with rsp_data_o=0x1.
REQ-035 Contention: req0 and req1 held continuously for 6 accesses from reset -> grant order 0,1,0,1,0,1.
REQ-036 Reset mid-ACCESS: assert rstn_i low during cycle 2 of a stalled access -> cfg_valid_o 0 immediately, no rsp pulse, next grant after reset goes to req0.
REQ-037 Timeout (macro on, TIMEOUT_CYC=4): cfg_ready_i held 0 -> rsp_valid_o after 4 ACCESS cycles with rsp_err_o=1 and rsp_data_o=0; macro off -> remains in ACCESS for 100 cycles.
